// File: rtl/modn_counter_pkg.sv
// Shared defaults and digit arithmetic for the cascaded modulo-N counter.
package modn_counter_pkg;

    localparam int unsigned DEF_MOD        = 10;
    localparam int unsigned DEF_NUM_DIGITS = 2;

    // Value at which a digit hands a carry/borrow to the next digit.
    function automatic int unsigned digit_terminal(input int unsigned mod, input logic up);
        return up ? (mod - 32'd1) : 32'd0;
    endfunction

    // One modulo step in the requested direction.
    function automatic int unsigned digit_next(input int unsigned value,
                                               input int unsigned mod,
                                               input logic        up);
        if (up) begin
            return (value == mod - 32'd1) ? 32'd0 : value + 32'd1;
        end
        return (value == 32'd0) ? (mod - 32'd1) : value - 32'd1;
    endfunction

endpackage

// File: rtl/modn_digit.sv
// Single modulo-MOD digit: reset > load > step, plus terminal and bad-load decode.
module modn_digit
    import modn_counter_pkg::*;
#(
    parameter int unsigned MOD = DEF_MOD,
    parameter int unsigned DW  = $clog2(MOD)
) (
    input  logic          clk1,
    input  logic          r,
    input  logic          load,
    input  logic [DW-1:0] load_digit,
    input  logic          step,
    input  logic          up,
    output logic [DW-1:0] value,
    output logic          at_terminal_c,
    output logic          load_err_c
);

    logic [DW-1:0] value_q;
    logic          load_ok;

    assign load_ok = (32'(load_digit) < MOD);

    always_ff @(posedge clk1) begin
        if (r) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_ok ? load_digit : '0;
        end else if (step) begin
            value_q <= DW'(digit_next(32'(value_q), MOD, up));
        end
    end

    assign value         = value_q;
    assign at_terminal_c = (32'(value_q) == digit_terminal(MOD, up));
    assign load_err_c    = load & ~load_ok;

endmodule

// File: rtl/modn_cascade_counter.sv
// Synchronous NUM_DIGITS x modulo-MOD up/down counter with load, terminal count and wrap pulse.
module modn_cascade_counter
    import modn_counter_pkg::*;
#(
    parameter int unsigned MOD        = DEF_MOD,
    parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int unsigned DW         = $clog2(MOD)
) (
    input  logic                     clk1,
    input  logic                     r,
    input  logic                     en,
    input  logic                     up,
    input  logic                     load,
    input  logic [NUM_DIGITS*DW-1:0] load_val,
    output logic [NUM_DIGITS*DW-1:0] count,
    output logic                     tc,
    output logic                     wrap,
    output logic                     load_err
);

    // chain[k] is high when digit k must step: en and all lower digits at terminal.
    logic [NUM_DIGITS:0]   chain;
    logic [NUM_DIGITS-1:0] at_term;
    logic [NUM_DIGITS-1:0] dig_err;
    logic                  wrap_q;
    logic                  load_err_q;

    assign chain[0] = en;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        modn_digit #(
            .MOD (MOD),
            .DW  (DW)
        ) u_digit (
            .clk1          (clk1),
            .r             (r),
            .load          (load),
            .load_digit    (load_val[k*DW +: DW]),
            .step          (chain[k]),
            .up            (up),
            .value         (count[k*DW +: DW]),
            .at_terminal_c (at_term[k]),
            .load_err_c    (dig_err[k])
        );
        assign chain[k+1] = chain[k] & at_term[k];
    end

    assign tc = chain[NUM_DIGITS];

    // Wrap pulses after a full-counter rollover; load_err is sticky until reset.
    always_ff @(posedge clk1) begin
        if (r) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q <= tc & ~load;
            if (|dig_err) begin
                load_err_q <= 1'b1;
            end
        end
    end

    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_modn_cascade_counter.sv
// Directed bench for modn_cascade_counter with an integer-valued reference model.
module tb_modn_cascade_counter;

    localparam int unsigned MOD = 10;
    localparam int unsigned ND  = 2;
    localparam int unsigned TOT = 100;

    logic       clk1 = 1'b0;
    logic       r = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] count;
    logic       tc, wrap, load_err;

    logic       r16 = 1'b1, en16 = 1'b0, up16 = 1'b1, load16 = 1'b0;
    logic [3:0] lv16 = 4'h0;
    logic [3:0] ca, cb;
    logic       tca, tcb, wra, wrb, lea, leb;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    int unsigned m_val = 0;
    bit          m_wrap = 1'b0;
    bit          m_err = 1'b0;

    always #5 clk1 = ~clk1;

    modn_cascade_counter #(.MOD(MOD), .NUM_DIGITS(ND)) dut (
        .clk1(clk1), .r(r), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    modn_cascade_counter #(.MOD(16), .NUM_DIGITS(1)) u16a (
        .clk1(clk1), .r(r16), .en(en16), .up(up16), .load(load16), .load_val(lv16),
        .count(ca), .tc(tca), .wrap(wra), .load_err(lea)
    );

    modn_cascade_counter #(.MOD(16), .NUM_DIGITS(1)) u16b (
        .clk1(clk1), .r(r16), .en(tca), .up(up16), .load(load16), .load_val(lv16),
        .count(cb), .tc(tcb), .wrap(wrb), .load_err(leb)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Integer value -> packed decimal digits.
    function automatic logic [7:0] pack(input int unsigned v);
        logic [7:0] p;
        p = 8'h00;
        for (int d = 0; d < 2; d++) begin
            p[d*4 +: 4] = 4'((v / (d == 0 ? 1 : MOD)) % MOD);
        end
        return p;
    endfunction

    // Reference: counter as a single integer modulo MOD^ND.
    always @(posedge clk1) begin
        if (r) begin
            m_val = 0; m_wrap = 1'b0; m_err = 1'b0;
        end else if (load) begin
            int unsigned s0, s1;
            s0 = 32'(load_val[3:0]);
            s1 = 32'(load_val[7:4]);
            if (s0 >= MOD) begin s0 = 0; m_err = 1'b1; end
            if (s1 >= MOD) begin s1 = 0; m_err = 1'b1; end
            m_val = s1 * MOD + s0;
            m_wrap = 1'b0;
        end else if (en) begin
            if (up) begin
                m_wrap = (m_val == TOT - 1);
                m_val  = (m_val + 1) % TOT;
            end else begin
                m_wrap = (m_val == 0);
                m_val  = (m_val + TOT - 1) % TOT;
            end
        end else begin
            m_wrap = 1'b0;
        end
    end

    always @(negedge clk1) begin
        if (chk_on) begin
            chk("count",    32'(count),    32'(pack(m_val)));
            chk("tc",       32'(tc),       32'(en && (up ? (m_val == TOT - 1) : (m_val == 0))));
            chk("wrap",     32'(wrap),     32'(m_wrap));
            chk("load_err", 32'(load_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    initial begin
        int wraps;

        tick();
        r = 1'b0;
        chk_on = 1'b1;
        chk("reset_count", 32'(count), 32'h00);
        chk("reset_wrap",  32'(wrap),  32'h0);

        // Up-count through a full wrap.
        en = 1'b1; up = 1'b1; wraps = 0;
        for (int i = 0; i < 105; i++) begin
            tick();
            if (wrap) wraps++;
        end
        en = 1'b0;
        chk("t1_final", 32'(count), 32'h05);
        chk("t1_model", 32'(pack(m_val)), 32'h05);
        chk("t1_wraps", 32'(wraps), 32'd1);

        // Down-count from 42 through 00 to 99.
        load = 1'b1; load_val = 8'h42;
        tick();
        load = 1'b0;
        chk("t2_load", 32'(count), 32'h42);
        en = 1'b1; up = 1'b0; wraps = 0;
        for (int i = 0; i < 43; i++) begin
            tick();
            if (wrap) wraps++;
        end
        en = 1'b0;
        chk("t2_final", 32'(count), 32'h99);
        chk("t2_wraps", 32'(wraps), 32'd1);

        // Invalid digit load and sticky error.
        load = 1'b1; load_val = 8'h3C;
        tick();
        chk("t3_count", 32'(count), 32'h30);
        chk("t3_err",   32'(load_err), 32'h1);
        load_val = 8'h21;
        tick();
        load = 1'b0;
        chk("t3_valid_count", 32'(count), 32'h21);
        chk("t3_sticky",      32'(load_err), 32'h1);
        r = 1'b1;
        tick();
        r = 1'b0;
        chk("t3_clear", 32'(load_err), 32'h0);

        // Reset beats load and en.
        load = 1'b1; load_val = 8'h57;
        tick();
        r = 1'b1; en = 1'b1; load_val = 8'h33;
        tick();
        chk("t4_count", 32'(count), 32'h00);
        chk("t4_wrap",  32'(wrap),  32'h0);
        load_val = 8'h99; r = 1'b0; en = 1'b0;
        tick();
        r = 1'b1; en = 1'b1; up = 1'b1;
        tick();
        chk("t4b_count", 32'(count), 32'h00);
        chk("t4b_wrap",  32'(wrap),  32'h0);
        r = 1'b0; en = 1'b0;
        load_val = 8'h99;
        tick();
        en = 1'b1;
        tick();
        load = 1'b0;
        chk("t4c_load_over_en", 32'(count), 32'h99);
        chk("t4c_wrap",         32'(wrap),  32'h0);
        en = 1'b0;

        // Direction toggling across a digit boundary, then hold.
        load = 1'b1; load_val = 8'h09;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        chk("t5_up1", 32'(count), 32'h10);
        up = 1'b0;
        tick();
        chk("t5_dn", 32'(count), 32'h09);
        up = 1'b1;
        tick();
        chk("t5_up2", 32'(count), 32'h10);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold", 32'(count), 32'h10);
        end

        // Single-digit modulo-16 instances: binary rollover and chained cascade.
        r16 = 1'b0; load16 = 1'b1; lv16 = 4'hF;
        tick();
        load16 = 1'b0; en16 = 1'b1;
        tick();
        chk("t6_roll",   32'(ca),  32'h0);
        chk("t6_wrap",   32'(wra), 32'h1);
        chk("t6_cas_b",  32'(cb),  32'h0);
        tick();
        chk("t6_wrap_1cyc", 32'(wra), 32'h0);
        en16 = 1'b0; r16 = 1'b1;
        tick();
        r16 = 1'b0; en16 = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            tick();
            chk("t6_cascade", 32'({cb, ca}), 32'(i % 256));
        end
        chk("t6_cas_wrap", 32'(wrb), 32'h1);
        en16 = 1'b0;

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
